// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: scheduler state encoding, pixel width and the
// 100 MHz timing defaults used by both the frame scheduler and the bit encoder.
package ws2812_pkg;

  localparam int GRB_W             = 24;
  localparam int LATCH_CYCLES_100M = 6000;
  localparam int FRAME_CYCLES_100M = 1666667;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_LATCH   = 3'd5
  } state_e;

endpackage

// File: rtl/ws2812_frame_timer.sv
// Free-running frame-rate timer: one tick per FRAME_CYCLES while auto_en is high,
// held at zero while auto_en is low.
module ws2812_frame_timer #(
  parameter int FRAME_CYCLES = 1666667
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic auto_en,
  output logic tick
);

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    tick  = auto_en && (cnt_q == 24'(FRAME_CYCLES - 1));
    cnt_d = cnt_q + 24'd1;
    if (!auto_en || tick) cnt_d = '0;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: streams NUM_LEDS pixels from the pixel RAM to the bit encoder,
// then enforces the latch gap before the next frame may start.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 40,
  parameter int AW           = 6,
  parameter int LATCH_CYCLES = LATCH_CYCLES_100M,
  parameter int FRAME_CYCLES = FRAME_CYCLES_100M
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             auto_en,
  input  logic             abort,
  output logic             pix_rd,
  output logic [AW-1:0]    pix_addr,
  input  logic [GRB_W-1:0] pix_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [GRB_W-1:0] px_grb,
  input  logic             enc_busy,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LAST_CNT  = LW'(LATCH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [GRB_W-1:0]   grb_q, grb_d;
  logic [LW-1:0]      lcnt_q, lcnt_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               rd_q, rd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick;
  logic               req;
  logic               streaming;

  ws2812_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .auto_en (auto_en),
    .tick    (tick)
  );

  // Handshake: px_grb moves to the encoder on a cycle where px_valid & px_ready;
  // px_valid stays high with px_grb frozen until that happens (abort excepted).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    grb_d     = grb_q;
    lcnt_d    = lcnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    req       = start | tick;
    streaming = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_PRESENT);

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (req || pending_q) begin
          state_d   = ST_FETCH;
          pending_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        grb_d   = pix_data;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (px_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (!enc_busy) begin
          state_d = ST_LATCH;
          lcnt_d  = '0;
        end
      end
      ST_LATCH: begin
        if (lcnt_q == LAST_CNT) state_d = ST_IDLE;
        else                    lcnt_d  = lcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A request that cannot start now is remembered once, and flagged.
    if (state_q != ST_IDLE && req) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    if (abort && streaming) begin
      state_d   = ST_DRAIN;
      pending_d = 1'b0;
    end

    rd_d    = (state_d == ST_FETCH);
    valid_d = (state_d == ST_PRESENT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_LATCH) && (lcnt_d == LAST_CNT);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      grb_q     <= '0;
      lcnt_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      grb_q     <= grb_d;
      lcnt_q    <= lcnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pix_rd     = rd_q;
  assign pix_addr   = addr_q;
  assign px_valid   = valid_q;
  assign px_grb     = grb_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Bench for ws2812_frame_sched: pixel RAM and encoder models, frame-level scoreboard,
// a timing table, randomized frames and directed overrun/auto/abort/reset sequences.
module tb_ws2812_frame_sched;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int L  = 50;
  localparam int FC = 5000;

  logic          sysclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          auto_en = 1'b0;
  logic          abort = 1'b0;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data = '0;
  logic          px_valid;
  logic          px_ready = 1'b1;
  logic [23:0]   px_grb;
  logic          enc_busy = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  ws2812_frame_sched #(.NUM_LEDS(N), .AW(AW), .LATCH_CYCLES(L), .FRAME_CYCLES(FC)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .abort(abort),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_grb(px_grb), .enc_busy(enc_busy),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  // clock / reset
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [23:0] ram [64];
  logic [23:0] exp_q[$];
  int          rise_q[$];
  int          done_q[$];
  int          checks = 0;
  int          errors = 0;

  int stall_px = -1, stall_left = 0, busy_hold = 0, busy_left = 0;
  int px_idx = 0, rd_cnt = 0, valid_cnt = 0;
  logic prev_busy = 1'b0;
  logic [23:0] ew;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // pixel RAM: data one cycle after the read strobe
  always @(posedge sysclk) if (pix_rd) pix_data <= ram[pix_addr];

  // encoder model + monitor
  always @(negedge sysclk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_left = 0;
      px_ready  = 1'b1;
      enc_busy  = 1'b0;
    end else begin
      enc_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (px_valid && px_idx == stall_px && stall_left > 0) begin
        px_ready = 1'b0;
        stall_left--;
        chk("stall_hold_grb", px_grb, ram[stall_px]);
      end else begin
        px_ready = 1'b1;
      end
      if (px_valid) valid_cnt++;
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
        else begin
          ew = exp_q.pop_front();
          chk("px_grb", px_grb, ew);
        end
        px_idx++;
        if (px_idx == N) busy_left = busy_hold;
      end
      if (pix_rd) rd_cnt++;
      if (frame_done) done_q.push_back(cyc);
      if (busy && !prev_busy) rise_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge sysclk) start = 1'b1;
    @(negedge sysclk) start = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(ram[i]);
  endtask

  task automatic wait_done(input int n_target, input int bound, input string nm);
    int t = 0;
    while (done_q.size() < n_target && t < bound) begin
      @(negedge sysclk);
      t++;
    end
    if (done_q.size() < n_target) chk({nm, "_timeout"}, 0, 1);
  endtask

  // One started frame; duration is busy-rise cycle to frame_done cycle.
  task automatic run_frame(input int sp, input int sl, input int b, input int exp_dur, input string nm);
    int n_d;
    stall_px = sp; stall_left = sl; busy_hold = b;
    px_idx = 0; rd_cnt = 0; valid_cnt = 0;
    push_frame();
    n_d = done_q.size();
    pulse_start();
    wait_done(n_d + 1, 5000, nm);
    if (done_q.size() > n_d) chk({nm, "_dur"}, done_q[$] - rise_q[$], exp_dur);
    chk({nm, "_rd_cnt"}, rd_cnt, N);
    chk({nm, "_valid_cycles"}, valid_cnt, N + ((sp >= 0) ? sl : 0));
    chk({nm, "_all_sent"}, exp_q.size(), 0);
    repeat (3) @(negedge sysclk);
  endtask

  typedef struct {
    int stall_px;
    int stall_len;
    int busy_hold;
    int exp_dur;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n_r, n_d, sp, sl, b, t, a_cyc;

    // 3 cycles per pixel, enc_busy hold and stalls add 1:1, then L latch cycles
    tbl[0] = '{-1,  0,   0, 3*N + L};
    tbl[1] = '{ 2, 50,   0, 3*N + L + 50};
    tbl[2] = '{-1,  0, 100, 3*N + L + 100};
    tbl[3] = '{ 1,  7,   3, 3*N + L + 10};
    tbl[4] = '{ 0,  1,   0, 3*N + L + 1};

    for (int i = 0; i < 64; i++) ram[i] = 24'h0A0B00 + 24'(i);

    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("rst_busy", busy, 0);
    chk("rst_pix_rd", pix_rd, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_px_grb", px_grb, 0);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].stall_px, tbl[i].stall_len, tbl[i].busy_hold, tbl[i].exp_dur, $sformatf("tbl%0d", i));

    // enc_busy held 100 cycles after last handshake: done 100+L+1 cycles later
    run_frame(-1, 0, 100, 3*N + L + 100, "last_hs_gap");

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
      sp = ($urandom_range(0, 4) == 4) ? -1 : int'($urandom_range(0, N - 1));
      sl = $urandom_range(0, 40);
      b  = $urandom_range(0, 30);
      run_frame(sp, sl, b, 3*N + L + b + ((sp >= 0) ? sl : 0), $sformatf("rnd%0d", k));
    end
    chk("no_overrun_yet", overrun, 0);

    // auto mode: frames every FC cycles, none after auto_en drops
    stall_px = -1; busy_hold = 0; px_idx = 0;
    for (int f = 0; f < 3; f++) push_frame();
    n_r = rise_q.size();
    n_d = done_q.size();
    @(negedge sysclk) auto_en = 1'b1;
    t = 0;
    while (rise_q.size() < n_r + 3 && t < 4 * FC) begin
      @(negedge sysclk);
      t++;
    end
    auto_en = 1'b0;
    chk("auto_three_frames", rise_q.size() - n_r, 3);
    if (rise_q.size() >= n_r + 3) begin
      chk("auto_period_1", rise_q[n_r + 1] - rise_q[n_r], FC);
      chk("auto_period_2", rise_q[n_r + 2] - rise_q[n_r + 1], FC);
    end
    wait_done(n_d + 3, 500, "auto_done");
    repeat (FC + FC / 5) @(negedge sysclk);
    chk("auto_off_no_frames", rise_q.size() - n_r, 3);
    chk("auto_all_sent", exp_q.size(), 0);
    chk("auto_no_overrun", overrun, 0);

    // two starts while busy: overrun, exactly one extra frame
    px_idx = 0;
    push_frame();
    push_frame();
    n_r = rise_q.size();
    n_d = done_q.size();
    pulse_start();
    repeat (5) @(negedge sysclk);
    pulse_start();
    repeat (5) @(negedge sysclk);
    pulse_start();
    wait_done(n_d + 2, 2000, "ovr_done");
    chk("ovr_flag", overrun, 1);
    chk("ovr_two_frames", rise_q.size() - n_r, 2);
    if (rise_q.size() >= n_r + 2 && done_q.size() > n_d)
      chk("ovr_restart_cycle", rise_q[n_r + 1], done_q[n_d] + 2);
    repeat (300) @(negedge sysclk);
    chk("ovr_no_third", rise_q.size() - n_r, 2);
    chk("ovr_all_sent", exp_q.size(), 0);

    // abort while fetching pixel 2: only pixels 0,1 go out, then DRAIN + latch gap
    for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
    px_idx = 0; rd_cnt = 0; valid_cnt = 0;
    exp_q.push_back(ram[0]);
    exp_q.push_back(ram[1]);
    n_d = done_q.size();
    pulse_start();
    t = 0;
    while (px_idx < 2 && t < 500) begin
      @(posedge sysclk);
      #1;
      t++;
    end
    abort = 1'b1;
    a_cyc = cyc;
    @(posedge sysclk);
    #1 abort = 1'b0;
    wait_done(n_d + 1, 500, "abort_done");
    if (done_q.size() > n_d) chk("abort_gap", done_q[$], a_cyc + 1 + L);
    chk("abort_px_count", px_idx, 2);
    chk("abort_rd_cnt", rd_cnt, 3);
    chk("abort_valid_cycles", valid_cnt, 2);
    chk("abort_all_sent", exp_q.size(), 0);
    repeat (3) @(negedge sysclk);

    // reset mid-LATCH: outputs drop asynchronously, IDLE afterwards
    px_idx = 0;
    push_frame();
    n_d = done_q.size();
    pulse_start();
    t = 0;
    while (px_idx < N && t < 500) begin
      @(negedge sysclk);
      t++;
    end
    repeat (10) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pix_rd", pix_rd, 0);
    chk("arst_px_valid", px_valid, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_pix_addr", pix_addr, 0);
    chk("arst_px_grb", px_grb, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_no_done_before", done_q.size(), n_d);
    chk("arst_frame_sent", exp_q.size(), 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("post_rst_idle", busy, 0);
    run_frame(-1, 0, 0, 3*N + L, "post_rst");
    chk("post_rst_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
